// File: rtl/commit_trace_buffer.sv
// Elastic FIFO between the write-back commit trace and the cosim checker, with overflow/watchdog fault flags.
// Optional COMMIT_TRACE_SEQNUM_EN adds out_seqnum, a per-record sequence number that is consumed by drops too.
module commit_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HARTID_W    = 1,
  parameter int unsigned WDOG_CYCLES = 65536
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [HARTID_W-1:0]       in_hartid,
  input  logic [63:0]               in_pc,
  input  logic [31:0]               in_inst,
  input  logic [63:0]               in_wdata,
  input  logic [6:0]                in_mstatus,
  input  logic                      in_int_xcpt,
  input  logic [63:0]               in_cause,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HARTID_W-1:0]       out_hartid,
  output logic [63:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic [63:0]               out_wdata,
  output logic [6:0]                out_mstatus,
  output logic                      out_int_xcpt,
  output logic [63:0]               out_cause,
`ifdef COMMIT_TRACE_SEQNUM_EN
  output logic [31:0]               out_seqnum,
`endif
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      timeout,
  output logic [15:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [1:0] {ARMED, RUN, FAULT} state_e;

  typedef struct packed {
    logic [HARTID_W-1:0] hartid;
    logic [63:0]         pc;
    logic [31:0]         inst;
    logic [63:0]         wdata;
    logic [6:0]          mstatus;
    logic                int_xcpt;
    logic [63:0]         cause;
`ifdef COMMIT_TRACE_SEQNUM_EN
    logic [31:0]         seqnum;
`endif
  } rec_t;

  rec_t        mem [DEPTH];
  rec_t        in_rec, head;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  state_e      state_q, state_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic        overflow_q, overflow_d, timeout_q, timeout_d;
  logic [15:0] drop_q, drop_d;
  logic        empty, full, accept, push, pop, drop, wdog_hit;
`ifdef COMMIT_TRACE_SEQNUM_EN
  logic [31:0] seq_q, seq_d;
`endif

  always_comb begin
    in_rec          = '0;
    in_rec.hartid   = in_hartid;
    in_rec.pc       = in_pc;
    in_rec.inst     = in_inst;
    in_rec.wdata    = in_wdata;
    in_rec.mstatus  = in_mstatus;
    in_rec.int_xcpt = in_int_xcpt;
    in_rec.cause    = in_cause;
`ifdef COMMIT_TRACE_SEQNUM_EN
    in_rec.seqnum   = seq_q;
`endif
  end

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign out_valid = !empty;
  assign level     = wr_q - rd_q;

  // Outputs are forced to zero while empty so stale storage never leaks out.
  assign head         = out_valid ? mem[rd_q[AW-1:0]] : '0;
  assign out_hartid   = head.hartid;
  assign out_pc       = head.pc;
  assign out_inst     = head.inst;
  assign out_wdata    = head.wdata;
  assign out_mstatus  = head.mstatus;
  assign out_int_xcpt = head.int_xcpt;
  assign out_cause    = head.cause;
`ifdef COMMIT_TRACE_SEQNUM_EN
  assign out_seqnum   = head.seqnum;
`endif

  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign drop_count = drop_q;

  always_comb begin
    accept     = in_valid && (state_q != FAULT);
    pop        = out_valid && out_ready;
    push       = accept && (!full || pop);
    drop       = accept && full && !pop;
    wdog_hit   = (WDOG_CYCLES != 0) && (state_q == RUN) && !in_valid
                 && (wdog_q == WW'(WDOG_CYCLES - 1));
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop  ? rd_q + 1'b1 : rd_q;
    overflow_d = overflow_q | drop;
    timeout_d  = timeout_q | wdog_hit;
    drop_d     = (drop && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;
    wdog_d     = wdog_q;
    if (in_valid)
      wdog_d = '0;
    else if ((state_q == RUN) && !wdog_hit)
      wdog_d = wdog_q + 1'b1;
    state_d = state_q;
    case (state_q)
      ARMED:   if (push) state_d = RUN;
      RUN:     if (drop || wdog_hit) state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

`ifdef COMMIT_TRACE_SEQNUM_EN
  assign seq_d = (push || drop) ? seq_q + 32'd1 : seq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) seq_q <= '0;
    else        seq_q <= seq_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_q[AW-1:0]] <= in_rec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      state_q    <= ARMED;
      wdog_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=16, WDOG_CYCLES=100, default build).
module tb_commit_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [0:0]  in_hartid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic [63:0] in_wdata;
  logic [6:0]  in_mstatus;
  logic        in_int_xcpt;
  logic [63:0] in_cause;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_hartid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] out_wdata;
  logic [6:0]  out_mstatus;
  logic        out_int_xcpt;
  logic [63:0] out_cause;
  logic [4:0]  level;
  logic        overflow;
  logic        timeout;
  logic [15:0] drop_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  commit_trace_buffer #(.DEPTH(16), .HARTID_W(1), .WDOG_CYCLES(100)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_hartid(in_hartid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_int_xcpt(in_int_xcpt), .in_cause(in_cause),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
    .out_mstatus(out_mstatus), .out_int_xcpt(out_int_xcpt), .out_cause(out_cause),
    .level(level), .overflow(overflow), .timeout(timeout), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pc_of(input int unsigned i);
    return 64'h8000_0000 + 64'(i) * 64'd4;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int unsigned i);
    in_valid    = 1'b1;
    in_hartid   = ~1'(i);
    in_pc       = pc_of(i);
    in_inst     = 32'h0000_0013 + (32'(i) << 20);
    in_wdata    = {32'hDEAD_0000 + 32'(i), 32'hBEEF_0000 + 32'(i)};
    in_mstatus  = 7'(i * 3 + 5);
    in_int_xcpt = ~i[1];
    in_cause    = 64'h8000_0000_0000_0000 | 64'(i + 7);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_hartid = '0; in_pc = '0; in_inst = '0; in_wdata = '0;
    in_mstatus = '0; in_int_xcpt = 1'b0; in_cause = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    tick();
    reset = 1'b1;

    // Single record, checker always ready
    out_ready = 1'b1;
    drive(0);
    #1;
    chk("t1_no_fallthrough", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", out_pc, 64'h8000_0000);
    chk("t1_level1", 64'(level), 64'd1);
    chk("t1_hartid", 64'(out_hartid), 64'd1);
    chk("t1_inst", 64'(out_inst), 64'h0000_0013);
    chk("t1_wdata", out_wdata, 64'hDEAD_0000_BEEF_0000);
    chk("t1_mstatus", 64'(out_mstatus), 64'd5);
    chk("t1_int_xcpt", 64'(out_int_xcpt), 64'd1);
    chk("t1_cause", out_cause, 64'h8000_0000_0000_0007);
    tick();
    chk("t1_level0", 64'(level), 64'd0);
    chk("t1_empty", 64'(out_valid), 64'd0);
    chk("t1_pc_zero", out_pc, 64'd0);

    // Fill, overflow, FAULT ignores further input, drain in order
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(i);
      tick();
    end
    chk("t2_level16", 64'(level), 64'd16);
    chk("t2_head_hold", out_pc, pc_of(1));
    chk("t2_no_ovf_yet", 64'(overflow), 64'd0);
    drive(17);
    tick();
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_drop1", 64'(drop_count), 64'd1);
    chk("t2_level_full", 64'(level), 64'd16);
    drive(18);
    tick();
    chk("t2_fault_nodrop", 64'(drop_count), 64'd1);
    out_ready = 1'b1;
    drive(19);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t2_drain_pc%0d", k), out_pc, pc_of(k));
      tick();
    end
    chk("t2_drained_level", 64'(level), 64'd0);
    chk("t2_drained_valid", 64'(out_valid), 64'd0);
    chk("t2_drop_final", 64'(drop_count), 64'd1);
    chk("t2_timeout", 64'(timeout), 64'd0);
    in_valid = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_reset();
    chk("t3_ovf_cleared", 64'(overflow), 64'd0);
    chk("t3_drop_cleared", 64'(drop_count), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(100 + i);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(116 + k);
      chk($sformatf("t3_order%0d", k), out_pc, pc_of(100 + k));
      tick();
      chk($sformatf("t3_level%0d", k), 64'(level), 64'd16);
    end
    chk("t3_no_overflow", 64'(overflow), 64'd0);
    chk("t3_no_drop", 64'(drop_count), 64'd0);
    in_valid = 1'b0;
    for (int k = 20; k < 36; k++) begin
      chk($sformatf("t3_tail%0d", k), out_pc, pc_of(100 + k));
      tick();
    end
    chk("t3_empty", 64'(level), 64'd0);

    // Watchdog: silent in ARMED, restarted by each commit, fires 100 cycles after last commit
    do_reset();
    out_ready = 1'b1;
    repeat (150) tick();
    chk("t4_armed_no_timeout", 64'(timeout), 64'd0);
    drive(200);
    tick();
    in_valid = 1'b0;
    repeat (60) tick();
    drive(201);
    tick();
    in_valid = 1'b0;
    repeat (99) tick();
    chk("t4_timeout_not_yet", 64'(timeout), 64'd0);
    tick();
    chk("t4_timeout_set", 64'(timeout), 64'd1);
    chk("t4_overflow_clear", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    drive(202);
    tick();
    in_valid = 1'b0;
    chk("t4_fault_ignores", 64'(level), 64'd0);
    chk("t4_timeout_sticky", 64'(timeout), 64'd1);

    // Asynchronous reset with queued records
    do_reset();
    chk("t5_timeout_cleared", 64'(timeout), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(300 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_level5", 64'(level), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_level", 64'(level), 64'd0);
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_pc", out_pc, 64'd0);
    tick();
    reset = 1'b1;
    drive(400);
    tick();
    in_valid = 1'b0;
    chk("t5_fresh_level", 64'(level), 64'd1);
    chk("t5_fresh_pc", out_pc, pc_of(400));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
